// File: rtl/index_unpack_fifo.sv
// Buffers packed index words and streams their indices out one per cycle, lane 0 first.
// Valid/ready on both sides; in_ready depends only on registered occupancy.
module index_unpack_fifo #(
  parameter int WORD_W = 64,
  parameter int IDX_W  = 16,
  parameter int DEPTH  = 4,
  localparam int LANES = WORD_W / IDX_W,
  localparam int CNT_W = $clog2(LANES + 1),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  input  logic [CNT_W-1:0]  in_count,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_index,
  output logic              out_last,
  output logic [LVL_W-1:0]  level
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic [WORD_W-1:0] word_mem_q [DEPTH];
  logic [WORD_W-1:0] word_mem_d [DEPTH];
  logic [CNT_W-1:0]  cnt_mem_q  [DEPTH];
  logic [CNT_W-1:0]  cnt_mem_d  [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [LVL_W-1:0]  level_q, level_d;

  logic [WORD_W-1:0] head_word;
  logic [CNT_W-1:0]  head_count;
  logic [CNT_W-1:0]  in_count_sat;
  logic [IDX_W-1:0]  lane_sel;
  logic              is_last;
  logic              push;
  logic              pop;
  logic              pop_word;

  assign head_word  = word_mem_q[rd_ptr_q];
  assign head_count = cnt_mem_q[rd_ptr_q];

  // Counts above LANES saturate so a bad producer can never index past the word.
  assign in_count_sat = (in_count > CNT_W'(LANES)) ? CNT_W'(LANES) : in_count;

  always_comb begin
    lane_sel = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_q == LANE_W'(i)) begin
        lane_sel = head_word[i*IDX_W +: IDX_W];
      end
    end
  end

  assign is_last   = (CNT_W'(lane_q) == (head_count - CNT_W'(1)));
  assign out_valid = (level_q != '0);
  assign in_ready  = (level_q != LVL_W'(DEPTH));
  assign out_index = out_valid ? lane_sel : '0;
  assign out_last  = out_valid && is_last;
  assign level     = level_q;

  // A zero-count word completes its handshake but never occupies a slot.
  assign push     = in_valid && in_ready && !flush && (in_count != '0);
  assign pop      = out_valid && out_ready && !flush;
  assign pop_word = pop && is_last;

  always_comb begin
    word_mem_d = word_mem_q;
    cnt_mem_d  = cnt_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    lane_d     = lane_q;
    level_d    = level_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      lane_d   = '0;
      level_d  = '0;
    end else begin
      if (push) begin
        word_mem_d[wr_ptr_q] = in_word;
        cnt_mem_d[wr_ptr_q]  = in_count_sat;
        wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        if (is_last) begin
          lane_d   = '0;
          rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end else begin
          lane_d = lane_q + LANE_W'(1);
        end
      end
      case ({push, pop_word})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      lane_q   <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      lane_q   <= lane_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: level gates every read of it.
  always_ff @(posedge clk) begin
    word_mem_q <= word_mem_d;
    cnt_mem_q  <= cnt_mem_d;
  end

endmodule
